axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Shares one AXI read slave (AR + R channels) between NM read masters.
- Arbitration is round-robin. One transaction is outstanding at a time.
- A grant is held from AR handshake until the handshake of the R beat that carries rlast.
- Checks the returned beat count against arlen and flags mismatches. Sits between bench/master agents and the slave memory model.

Parameters:
- WIDTH, 32, address and data width.
- NM, 2, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- aclk  in  1  clock
- arst  in  1  reset, synchronous, active-high
- m_arid  in  NM*4  per-master ARID, master i at [4i+3:4i]
- m_araddr  in  NM*WIDTH  per-master ARADDR
- m_arlen  in  NM*4  per-master ARLEN
- m_arsize  in  NM*3  per-master ARSIZE
- m_arburst  in  NM*2  per-master ARBURST
- m_arvalid  in  NM  per-master ARVALID
- m_arready  out  NM  per-master ARREADY
- m_rdata  out  WIDTH  RDATA broadcast to all masters
- m_rid  out  4  RID broadcast
- m_rresp  out  2  RRESP broadcast
- m_rlast  out  1  RLAST broadcast
- m_rvalid  out  NM  per-master RVALID (granted master only)
- m_rready  in  NM  per-master RREADY
- s_arid/s_araddr/s_arlen/s_arsize/s_arburst  out  4/WIDTH/4/3/2  muxed AR fields to slave
- s_arvalid  out  1  ARVALID to slave
- s_arready  in  1  ARREADY from slave
- s_rid/s_rdata/s_rresp/s_rlast  in  4/WIDTH/2/1  R channel from slave
- s_rvalid  in  1  RVALID from slave
- s_rready  out  1  RREADY to slave
- grant  out  NM  one-hot current grant; 0 when idle
- beat_err  out  1  sticky; beat count differed from arlen+1
- timeout_err  out  1  sticky; optional feature only, else tied 0

Behaviour:
- Reset: arst sampled on posedge aclk. All outputs go to 0: s_arvalid, s_rready, m_arready, m_rvalid, grant, beat_err, timeout_err. The last_grant pointer is set to NM-1, so master 0 has top priority after reset.
- A reset mid-burst abandons the transaction immediately; the slave side is not drained.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_arvalid is set, pick the first asserted index searching from last_grant+1 upward, mod NM.
  - Register the one-hot grant and go to ADDR.
  - Latency: m_arvalid high at edge N gives grant and s_arvalid high after edge N+1.
- ADDR:
  - s_ar* = fields of the granted master, combinational mux from grant; s_arvalid = 1.
  - m_arready[g] = s_arready; all other m_arready = 0.
  - On s_arvalid&&s_arready: capture arlen into len_q, clear beat_cnt, go to DATA.
  - Masters hold AR stable per AXI; the arbiter does not re-check m_arvalid in ADDR.
- DATA:
  - s_arvalid = 0.
  - m_rvalid[g] = s_rvalid; other m_rvalid = 0.
  - s_rready = m_rready[g].
  - m_r* broadcast from s_r*.
  - Each s_rvalid&&s_rready: beat_cnt++ (5-bit).
  - On the beat with s_rlast=1: if beat_cnt+1 != len_q+1, set beat_err. Set last_grant = g, clear grant, go to IDLE.
- Fairness: a master granted for the previous transaction becomes lowest priority. With both of 2 masters requesting continuously, grants alternate 0,1,0,1.
- Back-to-back: IDLE is always visited for 1 cycle between transactions, giving minimum 1 bubble cycle between rlast handshake and the next s_arvalid.
- Beat-count overflow: if beat_cnt reaches 16 without rlast, set beat_err. Stay in DATA and keep forwarding; do not wrap silently (counter saturates at 16).
- beat_err and timeout_err clear only on arst.

Optional Feature:
- Macro: AXI_RD_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter runs in DATA, cleared on every R handshake and on entry to DATA.
  - If it reaches TIMEOUT_CYCLES, set timeout_err, force s_rready=1 for one cycle, clear grant, update last_grant and return to IDLE.
  - R beats after that are not forwarded to any master.
- Not defined: no counter logic; timeout_err is tied to 0 and DATA waits indefinitely.

Test Plan:
- Master 0 alone: araddr=0x10, arlen=3. Expect s_araddr=0x10, 4 beats forwarded to m_rvalid[0] only, grant returns to 0 after rlast, beat_err=0.
- Masters 0 and 1 assert arvalid on the same cycle after reset. Expect master 0 served first, then master 1, with 1 idle cycle between rlast handshake and s_arvalid.
- Both masters requesting continuously for 6 transactions with arlen=0. Expect grant sequence 0,1,0,1,0,1.
- Slave rvalid held high, m_rready[1] toggled 1,0,0,1. Expect s_rready to mirror it exactly; beats not lost or duplicated; m_rvalid[0] stays 0.
- Slave returns rlast on beat 2 with arlen=3. Expect beat_err=1 at the next edge, FSM back in IDLE, beat_err sticky until arst.
- arst asserted during beat 2 of an arlen=7 burst. Expect all outputs 0 next edge, then master 0 priority on next request. With AXI_RD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: no rvalid for 8 cycles gives timeout_err=1 and grant=0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read slave (AR + R) between NM masters.
// Optional watchdog on the R phase: define AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arbiter #(
    parameter int WIDTH          = 32,
    parameter int NM             = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [NM*4-1:0]     m_arid,
    input  logic [NM*WIDTH-1:0] m_araddr,
    input  logic [NM*4-1:0]     m_arlen,
    input  logic [NM*3-1:0]     m_arsize,
    input  logic [NM*2-1:0]     m_arburst,
    input  logic [NM-1:0]       m_arvalid,
    output logic [NM-1:0]       m_arready,
    output logic [WIDTH-1:0]    m_rdata,
    output logic [3:0]          m_rid,
    output logic [1:0]          m_rresp,
    output logic                m_rlast,
    output logic [NM-1:0]       m_rvalid,
    input  logic [NM-1:0]       m_rready,
    output logic [3:0]          s_arid,
    output logic [WIDTH-1:0]    s_araddr,
    output logic [3:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [3:0]          s_rid,
    input  logic [WIDTH-1:0]    s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [NM-1:0]       grant,
    output logic                beat_err,
    output logic                timeout_err
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} st_t;

    st_t            r_state;
    st_t            w_next;
    logic [NM-1:0]  r_grant;
    logic [IW-1:0]  r_gidx;
    logic [IW-1:0]  r_last;
    logic [3:0]     r_len;
    logic [4:0]     r_cnt;
    logic           r_beat_err;
    logic [IW-1:0]  w_pick;
    logic [NM-1:0]  w_onehot;
    logic           w_found;
    int             w_idx;
    logic           w_arhs;
    logic           w_rhs;
    logic           w_to;

    // Round-robin search starting just above the last granted master
    always_comb begin
        w_found  = 1'b0;
        w_pick   = '0;
        w_idx    = 0;
        w_onehot = '0;
        for (int k = 1; k <= NM; k++) begin
            w_idx = (int'(r_last) + k) % NM;
            if (!w_found && m_arvalid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IW'(w_idx);
            end
        end
        w_onehot[w_pick] = 1'b1;
    end

    assign w_arhs = (r_state == ADDR) && s_arready;
    assign w_rhs  = (r_state == DATA) && s_rvalid && m_rready[r_gidx] && !w_to;

`ifdef AXI_RD_ARB_TIMEOUT_EN
    logic [15:0] r_wd;
    logic        r_to_err;

    assign w_to        = (r_state == DATA) && (r_wd >= 16'(TIMEOUT_CYCLES));
    assign timeout_err = r_to_err;

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_wd     <= '0;
            r_to_err <= 1'b0;
        end else begin
            if (w_arhs || w_rhs || w_to)
                r_wd <= '0;
            else if (r_state == DATA)
                r_wd <= r_wd + 16'd1;
            if (w_to)
                r_to_err <= 1'b1;
        end
    end
`else
    assign w_to        = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (arst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_found) w_next = ADDR;
            ADDR: if (s_arready) w_next = DATA;
            DATA: if ((w_rhs && s_rlast) || w_to) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        unique case (r_state)
            ADDR: begin
                s_arvalid = 1'b1;
                m_arready = r_grant & {NM{s_arready}};
            end
            DATA: begin
                s_rready = m_rready[r_gidx] | w_to;
                m_rvalid = w_to ? '0 : (r_grant & {NM{s_rvalid}});
            end
            default: ;
        endcase
    end

    assign s_arid    = m_arid[4*r_gidx +: 4];
    assign s_araddr  = m_araddr[WIDTH*r_gidx +: WIDTH];
    assign s_arlen   = m_arlen[4*r_gidx +: 4];
    assign s_arsize  = m_arsize[3*r_gidx +: 3];
    assign s_arburst = m_arburst[2*r_gidx +: 2];

    assign m_rdata  = s_rdata;
    assign m_rid    = s_rid;
    assign m_rresp  = s_rresp;
    assign m_rlast  = s_rlast;
    assign grant    = r_grant;
    assign beat_err = r_beat_err;

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_grant    <= '0;
            r_gidx     <= '0;
            r_last     <= IW'(NM - 1);
            r_len      <= '0;
            r_cnt      <= '0;
            r_beat_err <= 1'b0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_grant <= w_onehot;
                r_gidx  <= w_pick;
            end
            if (w_arhs) begin
                r_len <= s_arlen;
                r_cnt <= '0;
            end
            if (w_rhs) begin
                if (s_rlast) begin
                    if (r_cnt != {1'b0, r_len})
                        r_beat_err <= 1'b1;
                    r_last  <= r_gidx;
                    r_grant <= '0;
                end else begin
                    // Saturate at 16 beats; the 16th non-last beat is an error
                    if (r_cnt != 5'd16)
                        r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd15)
                        r_beat_err <= 1'b1;
                end
            end
            if (w_to) begin
                r_last  <= r_gidx;
                r_grant <= '0;
            end
        end
    end

endmodule
